ieee1355_tx_sched: RTL and testbench

IEEE1355_TX_SCHED -- requirements
Module: ieee1355_tx_sched

---
 rtl/ieee1355_tx_sched.sv | 92 +++++++++
 tb/tb_ieee1355_tx_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ieee1355_tx_sched.sv
// ieee1355_tx_sched: link state sequencing, credit tracking and round-robin byte scheduling for an IEEE 1355 transmitter
//   clk, rst      : single clock, synchronous active-high reset
//   link_en       : 1 brings the link up, 0 forces it down
//   req, req_data : per-requester request level and byte (requester i at [8i+7:8i])
//   grant         : one-hot pulse, requester byte accepted
//   tx_ready      : serialiser samples tx_char this cycle
//   tx_char       : registered next character (NULL or {2'b00, byte})
//   link_state    : 00 DISABLED, 01 STARTUP, 10 RUN
//   credit_add    : remote end granted G_CREDIT_STEP credits
//   credit_cnt    : current credit count
//   credit_err    : sticky credit overflow flag
module ieee1355_tx_sched #(
  parameter int G_NUM_REQ       = 4,
  parameter int G_STARTUP_NULLS = 7,
  parameter int G_CREDIT_STEP   = 8,
  parameter int G_CREDIT_MAX    = 56
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   link_en,
  input  logic [G_NUM_REQ-1:0]   req,
  input  logic [8*G_NUM_REQ-1:0] req_data,
  output logic [G_NUM_REQ-1:0]   grant,
  input  logic                   tx_ready,
  output logic [9:0]             tx_char,
  output logic [1:0]             link_state,
  input  logic                   credit_add,
  output logic [5:0]             credit_cnt,
  output logic                   credit_err
);
  localparam logic [9:0] NULL_CHAR = 10'b1111000110;
  localparam int PW = G_NUM_REQ > 1 ? $clog2(G_NUM_REQ) : 1;
  localparam int SW = $clog2(G_STARTUP_NULLS + 1);
  localparam logic [6:0] CMAX = 7'(G_CREDIT_MAX);
  localparam logic [6:0] CSTEP = 7'(G_CREDIT_STEP);
  typedef enum logic [1:0] {DISABLED = 2'b00, STARTUP = 2'b01, RUN = 2'b10} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, win;
  logic [SW-1:0] su_cnt;
  logic found, take, add;
  logic [6:0] sum;
  int idx;
  assign link_state = state;
  always_comb begin
    state_nx = !link_en ? DISABLED :
               state == DISABLED ? STARTUP :
               (state == STARTUP && tx_ready && su_cnt == SW'(G_STARTUP_NULLS - 1)) ? RUN : state;
  end
  // Round-robin search starting at ptr, first requester found wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < G_NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % G_NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win = PW'(idx);
      end
    end
  end
  // Adding and consuming in the same cycle both apply before saturation.
  assign take = state == RUN && link_en && tx_ready && found && credit_cnt != '0;
  assign add = credit_add && link_en && state != DISABLED;
  assign sum = {1'b0, credit_cnt} + (add ? CSTEP : 7'd0) - {6'd0, take};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DISABLED;
      tx_char <= NULL_CHAR;
      grant <= '0;
      credit_cnt <= '0;
      credit_err <= 1'b0;
      ptr <= '0;
      su_cnt <= '0;
    end else begin
      state <= state_nx;
      grant <= take ? G_NUM_REQ'(1) << win : '0;
      if (!link_en || state == DISABLED) begin
        tx_char <= NULL_CHAR;
        credit_cnt <= '0;
        credit_err <= 1'b0;
        su_cnt <= '0;
      end else begin
        if (tx_ready) tx_char <= take ? {2'b00, req_data[8*win +: 8]} : NULL_CHAR;
        if (state == STARTUP && tx_ready) su_cnt <= su_cnt + 1'b1;
        credit_cnt <= sum > CMAX ? CMAX[5:0] : sum[5:0];
        if (sum > CMAX) credit_err <= 1'b1;
        if (take) ptr <= win == PW'(G_NUM_REQ - 1) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ieee1355_tx_sched.sv
// tb_ieee1355_tx_sched: directed self-checking bench for ieee1355_tx_sched
module tb_ieee1355_tx_sched;
  localparam logic [9:0] NUL = 10'b1111000110;
  logic clk = 0, rst = 0, link_en = 0, tx_ready = 0, credit_add = 0;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] grant;
  logic [9:0] tx_char;
  logic [1:0] link_state;
  logic [5:0] credit_cnt;
  logic credit_err;
  int n_cmp = 0, n_err = 0;
  ieee1355_tx_sched dut (
    .clk(clk), .rst(rst), .link_en(link_en), .req(req), .req_data(req_data),
    .grant(grant), .tx_ready(tx_ready), .tx_char(tx_char), .link_state(link_state),
    .credit_add(credit_add), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_ready();
    tx_ready = 1;
    step();
    tx_ready = 0;
  endtask
  task automatic pulse_credit();
    credit_add = 1;
    step();
    credit_add = 0;
  endtask
  task automatic bring_up();
    link_en = 1;
    step();
    repeat (7) pulse_ready();
  endtask
  task automatic test_reset();
    rst = 1; link_en = 1; tx_ready = 1; credit_add = 1;
    step();
    n_cmp++;
    if ({link_state, grant, tx_char, credit_cnt, credit_err} !== {2'b00, 4'b0, NUL, 6'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: state=%b grant=%b char=%h credit=%0d err=%b", link_state, grant, tx_char, credit_cnt, credit_err);
    end
    rst = 0; link_en = 0; tx_ready = 0; credit_add = 0;
    step();
  endtask
  task automatic test_startup();
    link_en = 1;
    step();
    n_cmp++;
    if (link_state !== 2'b01) begin n_err++; $display("FAIL startup_enter: state=%b want 01", link_state); end
    for (int i = 1; i <= 7; i++) begin
      pulse_ready();
      n_cmp++;
      if ({link_state, grant, tx_char} !== {(i == 7) ? 2'b10 : 2'b01, 4'b0, NUL}) begin
        n_err++;
        $display("FAIL startup_null%0d: state=%b grant=%b char=%h", i, link_state, grant, tx_char);
      end
    end
  endtask
  task automatic test_round_robin();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_credit();
    n_cmp++;
    if (credit_cnt !== 6'd8) begin n_err++; $display("FAIL rr_credit_add: credit=%0d want 8", credit_cnt); end
    req = 4'b1111; req_data = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      pulse_ready();
      n_cmp++;
      if ({grant, tx_char} !== {4'b0001 << i, 2'b00, b[i]}) begin
        n_err++;
        $display("FAIL rr_grant%0d: grant=%b char=%h want grant=%b char=%h", i, grant, tx_char, 4'b0001 << i, {2'b00, b[i]});
      end
      step();
      n_cmp++;
      if (grant !== 4'b0) begin n_err++; $display("FAIL rr_pulse%0d: grant=%b want 0000", i, grant); end
    end
    n_cmp++;
    if (credit_cnt !== 6'd4) begin n_err++; $display("FAIL rr_credit: credit=%0d want 4", credit_cnt); end
    req = '0;
  endtask
  task automatic test_no_credit();
    req = 4'b0001; req_data = 32'h000000AB;
    repeat (4) pulse_ready();
    n_cmp++;
    if ({credit_cnt, tx_char} !== {6'd0, 10'h0AB}) begin
      n_err++;
      $display("FAIL drain: credit=%0d char=%h want 0 0ab", credit_cnt, tx_char);
    end
    req = 4'b0100; req_data = 32'h005A0000;
    pulse_ready();
    n_cmp++;
    if ({grant, tx_char, credit_cnt} !== {4'b0, NUL, 6'd0}) begin
      n_err++;
      $display("FAIL nocredit_null: grant=%b char=%h credit=%0d", grant, tx_char, credit_cnt);
    end
    pulse_credit();
    pulse_ready();
    n_cmp++;
    if ({grant, tx_char, credit_cnt} !== {4'b0100, 10'h05A, 6'd7}) begin
      n_err++;
      $display("FAIL nocredit_grant: grant=%b char=%h credit=%0d want 0100 05a 7", grant, tx_char, credit_cnt);
    end
    req = '0;
  endtask
  task automatic test_saturation();
    link_en = 0;
    step();
    bring_up();
    repeat (7) pulse_credit();
    n_cmp++;
    if ({credit_cnt, credit_err} !== {6'd56, 1'b0}) begin
      n_err++;
      $display("FAIL sat_fill: credit=%0d err=%b want 56 0", credit_cnt, credit_err);
    end
    req = 4'b0001; req_data = 32'h00000001;
    repeat (6) pulse_ready();
    req = '0;
    n_cmp++;
    if (credit_cnt !== 6'd50) begin n_err++; $display("FAIL sat_50: credit=%0d want 50", credit_cnt); end
    pulse_credit();
    n_cmp++;
    if ({credit_cnt, credit_err} !== {6'd56, 1'b1}) begin
      n_err++;
      $display("FAIL sat_overflow: credit=%0d err=%b want 56 1", credit_cnt, credit_err);
    end
    link_en = 0;
    step();
    n_cmp++;
    if ({link_state, credit_cnt, credit_err} !== {2'b00, 6'd0, 1'b0}) begin
      n_err++;
      $display("FAIL sat_disable: state=%b credit=%0d err=%b want 00 0 0", link_state, credit_cnt, credit_err);
    end
  endtask
  task automatic test_sat_consume();
    bring_up();
    repeat (7) pulse_credit();
    req = 4'b0010; req_data = 32'h0000C300;
    credit_add = 1; tx_ready = 1;
    step();
    credit_add = 0; tx_ready = 0; req = '0;
    n_cmp++;
    if ({grant, tx_char, credit_cnt, credit_err} !== {4'b0010, 10'h0C3, 6'd56, 1'b1}) begin
      n_err++;
      $display("FAIL sat_consume: grant=%b char=%h credit=%0d err=%b want 0010 0c3 56 1", grant, tx_char, credit_cnt, credit_err);
    end
  endtask
  task automatic test_link_drop();
    req = 4'b1000; req_data = 32'h77000000;
    pulse_ready();
    n_cmp++;
    if ({grant, tx_char} !== {4'b1000, 10'h077}) begin
      n_err++;
      $display("FAIL drop_grant: grant=%b char=%h want 1000 077", grant, tx_char);
    end
    link_en = 0;
    step();
    n_cmp++;
    if ({link_state, grant, tx_char} !== {2'b00, 4'b0, NUL}) begin
      n_err++;
      $display("FAIL drop_null: state=%b grant=%b char=%h", link_state, grant, tx_char);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_ready();
      n_cmp++;
      if ({link_state, grant, tx_char} !== {2'b00, 4'b0, NUL}) begin
        n_err++;
        $display("FAIL drop_hold%0d: state=%b grant=%b char=%h", i, link_state, grant, tx_char);
      end
    end
    link_en = 1;
    pulse_ready();
    n_cmp++;
    if ({link_state, grant, tx_char, credit_cnt} !== {2'b01, 4'b0, NUL, 6'd0}) begin
      n_err++;
      $display("FAIL relink: state=%b grant=%b char=%h credit=%0d", link_state, grant, tx_char, credit_cnt);
    end
    req = '0;
  endtask
  initial begin
    step();
    test_reset();
    test_startup();
    test_round_robin();
    test_no_credit();
    test_saturation();
    test_sat_consume();
    test_link_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
